// File: rtl/game_pkg.sv
// Shared game constants: pixel format, transparent colour key and the
// sprite layer indices used to build the collision groups.
package game_pkg;

    localparam int RGB_W = 12;
    localparam logic [RGB_W-1:0] KEY_RGB = 12'h000;

    // Sprite layer indices; lower index is drawn on top.
    localparam int MYPLANE  = 0;
    localparam int ENEMY    = 1;
    localparam int BOSS     = 2;
    localparam int MYBULLET = 3;
    localparam int EBULLET  = 4;

endpackage

// File: rtl/prio_select.sv
// Priority select: picks the colour of the lowest-index opaque layer,
// falling back to the background colour when no layer is opaque.
module prio_select #(
    parameter int N_LAYERS = 6,
    parameter int RGB_W    = game_pkg::RGB_W
) (
    input  logic [N_LAYERS-1:0]       opaque_i,
    input  logic [N_LAYERS*RGB_W-1:0] rgb_i,
    input  logic [RGB_W-1:0]          bg_i,
    output logic [RGB_W-1:0]          rgb_o
);

    logic [N_LAYERS-1:0] first_oh;

    // Isolate the lowest set bit (x & -x) to get a one-hot winner.
    assign first_oh = opaque_i & (~opaque_i + N_LAYERS'(1));

    // AND-OR mux over the one-hot winner; background when nothing is opaque.
    always_comb begin
        // NOTE: rgb_o gets a value before the loop so every path assigns it
        // and no latch is inferred.
        rgb_o = (|opaque_i) ? '0 : bg_i;
        for (int i = 0; i < N_LAYERS; i++) begin
            rgb_o = rgb_o | ({RGB_W{first_oh[i]}} & rgb_i[i*RGB_W +: RGB_W]);
        end
    end

endmodule

// File: rtl/layer_compositor.sv
// Two-stage sprite layer compositor with per-frame collision detection
// between two layer groups and a saturating count of colliding frames.
module layer_compositor
    import game_pkg::MYPLANE, game_pkg::ENEMY, game_pkg::BOSS;
#(
    parameter int                   N_LAYERS = 6,
    parameter int                   RGB_W    = game_pkg::RGB_W,
    parameter logic [RGB_W-1:0]     KEY_RGB  = RGB_W'(game_pkg::KEY_RGB),
    parameter logic [N_LAYERS-1:0]  MASK_A   = N_LAYERS'(1 << MYPLANE),
    parameter logic [N_LAYERS-1:0]  MASK_B   = N_LAYERS'((1 << ENEMY) | (1 << BOSS))
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pix_valid,
    input  logic                      frame_end,
    input  logic                      play_en,
    input  logic [N_LAYERS-1:0]       layer_en,
    input  logic [N_LAYERS*RGB_W-1:0] layer_rgb,
    input  logic [RGB_W-1:0]          bg_rgb,
    input  logic [RGB_W-1:0]          start_rgb,
    output logic [RGB_W-1:0]          out_rgb,
    output logic                      out_valid,
    output logic                      hit,
    output logic [7:0]                hit_count
);

    // Stage 1 registers
    logic [N_LAYERS-1:0]       opaque_d, opaque_q;
    logic [N_LAYERS*RGB_W-1:0] rgb_q;
    logic [RGB_W-1:0]          bg_q, start_q;
    logic                      play_q, valid_q;

    // Stage 2 and frame-level registers
    logic [RGB_W-1:0] out_rgb_d, out_rgb_q;
    logic             out_valid_q;
    logic             frame_hit_d, frame_hit_q;
    logic             hit_d, hit_q;
    logic [7:0]       hit_count_d, hit_count_q;

    logic [RGB_W-1:0] layer_pix;
    logic             collision;

    // A layer is opaque when covering an active pixel with a non-key colour.
    always_comb begin
        opaque_d = '0;
        for (int i = 0; i < N_LAYERS; i++) begin
            opaque_d[i] = pix_valid && layer_en[i] &&
                          (layer_rgb[i*RGB_W +: RGB_W] != KEY_RGB);
        end
    end

    // Stage 1: capture coverage and all colour sources for this pixel.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: every pipeline register is reset so no pixel captured
        // before reset can reach out_rgb afterwards.
        if (!rst) begin
            opaque_q <= '0;
            rgb_q    <= '0;
            bg_q     <= '0;
            start_q  <= '0;
            play_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            // NOTE: registered state uses non-blocking assignment so every
            // flop samples pre-edge values regardless of statement order.
            opaque_q <= opaque_d;
            rgb_q    <= layer_rgb;
            bg_q     <= bg_rgb;
            start_q  <= start_rgb;
            play_q   <= play_en;
            valid_q  <= pix_valid;
        end
    end

    prio_select #(
        .N_LAYERS (N_LAYERS),
        .RGB_W    (RGB_W)
    ) u_prio_select (
        .opaque_i (opaque_q),
        .rgb_i    (rgb_q),
        .bg_i     (bg_q),
        .rgb_o    (layer_pix)
    );

    // Collision is judged on the stage-1 pixel, so the last pixel of a frame
    // is evaluated in the same cycle as that frame's frame_end pulse.
    assign collision = play_q && (|(opaque_q & MASK_A)) && (|(opaque_q & MASK_B));

    // Output colour, frame flag and hit counter next-state.
    always_comb begin
        if (!valid_q) begin
            out_rgb_d = '0;
        end else if (!play_q) begin
            out_rgb_d = start_q;
        end else begin
            out_rgb_d = layer_pix;
        end

        hit_d       = frame_end && (frame_hit_q || collision);
        frame_hit_d = frame_end ? 1'b0 : (frame_hit_q || collision);
        hit_count_d = (hit_d && (hit_count_q != 8'hFF)) ? hit_count_q + 8'd1
                                                        : hit_count_q;
    end

    // Stage 2 and frame-level state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_rgb_q   <= '0;
            out_valid_q <= 1'b0;
            frame_hit_q <= 1'b0;
            hit_q       <= 1'b0;
            hit_count_q <= 8'h00;
        end else begin
            out_rgb_q   <= out_rgb_d;
            out_valid_q <= valid_q;
            frame_hit_q <= frame_hit_d;
            hit_q       <= hit_d;
            hit_count_q <= hit_count_d;
        end
    end

    assign out_rgb   = out_rgb_q;
    assign out_valid = out_valid_q;
    assign hit       = hit_q;
    assign hit_count = hit_count_q;

endmodule

// File: tb/tb_layer_compositor.sv
// Self-checking bench for layer_compositor: a frame-level model predicts
// every output each cycle; literal checks pin the key scenarios.
module tb_layer_compositor;

    localparam int NL = 6;
    localparam int W  = 12;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            pix_valid = 1'b0;
    logic            frame_end = 1'b0;
    logic            play_en = 1'b1;
    logic [NL-1:0]   layer_en = '0;
    logic [NL*W-1:0] layer_rgb = '0;
    logic [W-1:0]    bg_rgb = 12'h00F;
    logic [W-1:0]    start_rgb = 12'hABC;
    logic [W-1:0]    out_rgb;
    logic            out_valid;
    logic            hit;
    logic [7:0]      hit_count;

    int tests_run = 0;
    int tests_failed = 0;
    bit chk_en = 1'b0;

    // Model state: outputs expected after the latest edge, pixel in flight,
    // and whether the current frame has seen a collision so far.
    logic [W-1:0] m_rgb = '0, p1_rgb = '0;
    logic         m_val = 1'b0, p1_val = 1'b0;
    logic         m_hit = 1'b0;
    logic [7:0]   m_cnt = 8'h00;
    bit           frame_acc = 1'b0;

    layer_compositor dut (
        .clk       (clk),
        .rst       (rst),
        .pix_valid (pix_valid),
        .frame_end (frame_end),
        .play_en   (play_en),
        .layer_en  (layer_en),
        .layer_rgb (layer_rgb),
        .bg_rgb    (bg_rgb),
        .start_rgb (start_rgb),
        .out_rgb   (out_rgb),
        .out_valid (out_valid),
        .hit       (hit),
        .hit_count (hit_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [NL*W-1:0] pk(input logic [W-1:0] l0, input logic [W-1:0] l1,
                                           input logic [W-1:0] l2, input logic [W-1:0] l3);
        return {12'h000, 12'h000, l3, l2, l1, l0};
    endfunction

    function automatic bit is_opaque(input logic v, input logic [NL-1:0] en,
                                     input logic [NL*W-1:0] rgb, input int i);
        logic [W-1:0] c;
        c = rgb[i*W +: W];
        return v && en[i] && (c != 12'h000);
    endfunction

    // Displayed colour: blank, attract screen, topmost visible sprite, or background.
    function automatic logic [W-1:0] ref_pix(input logic v, input logic pe,
                                             input logic [NL-1:0] en, input logic [NL*W-1:0] rgb,
                                             input logic [W-1:0] bg, input logic [W-1:0] st);
        if (!v) return '0;
        if (!pe) return st;
        for (int i = 0; i < NL; i++)
            if (is_opaque(v, en, rgb, i)) return rgb[i*W +: W];
        return bg;
    endfunction

    // Player plane overlapping an enemy or the boss during play.
    function automatic bit ref_coll(input logic v, input logic pe,
                                    input logic [NL-1:0] en, input logic [NL*W-1:0] rgb);
        return pe && is_opaque(v, en, rgb, 0) &&
               (is_opaque(v, en, rgb, 1) || is_opaque(v, en, rgb, 2));
    endfunction

    // Apply one cycle of inputs, advance the model at the edge, return at negedge.
    task automatic step(input logic v, input logic fe, input logic pe,
                        input logic [NL-1:0] en, input logic [NL*W-1:0] rgb);
        bit c, h;
        pix_valid = v;
        frame_end = fe;
        play_en   = pe;
        layer_en  = en;
        layer_rgb = rgb;
        c = ref_coll(v, pe, en, rgb);
        @(posedge clk);
        h = fe && frame_acc;
        m_rgb  = p1_rgb;
        m_val  = p1_val;
        p1_rgb = ref_pix(v, pe, en, rgb, bg_rgb, start_rgb);
        p1_val = v;
        if (fe) frame_acc = 1'b0;
        if (c) frame_acc = 1'b1;
        m_hit = h;
        if (h && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        @(negedge clk);
    endtask

    task automatic pixel(input logic [NL-1:0] en, input logic [NL*W-1:0] rgb);
        step(1'b1, 1'b0, 1'b1, en, rgb);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b1, '0, '0);
    endtask

    task automatic fend();
        step(1'b0, 1'b1, 1'b1, '0, '0);
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must clear at once.
    task automatic mid_reset();
        pix_valid = 1'b0;
        frame_end = 1'b0;
        layer_en  = '0;
        #2;
        rst = 1'b0;
        m_rgb = '0; m_val = 1'b0; m_hit = 1'b0; m_cnt = 8'h00;
        p1_rgb = '0; p1_val = 1'b0; frame_acc = 1'b0;
        #1;
        check("rst_out_rgb", 32'(out_rgb), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_hit", 32'(hit), 32'h0);
        check("rst_hit_count", 32'(hit_count), 32'h0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Per-cycle comparison of all outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("model_out_rgb", 32'(out_rgb), 32'(m_rgb));
                check("model_out_valid", 32'(out_valid), 32'(m_val));
                check("model_hit", 32'(hit), 32'(m_hit));
                check("model_hit_count", 32'(hit_count), 32'(m_cnt));
            end
        end
    end

    localparam logic [NL-1:0] EN_OVL = 6'b000101;

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("init_out_rgb", 32'(out_rgb), 32'h0);
        check("init_out_valid", 32'(out_valid), 32'h0);
        check("init_hit_count", 32'(hit_count), 32'h0);
        rst = 1'b1;
        idle();

        // Layer 1 above layer 2; two-cycle latency; then blanking.
        pixel(6'b000110, pk(12'h000, 12'hF00, 12'h0F0, 12'h000));
        idle();
        check("prio_l1_rgb", 32'(out_rgb), 32'hF00);
        check("prio_l1_valid", 32'(out_valid), 32'h1);
        idle();
        check("blank_rgb", 32'(out_rgb), 32'h0);
        check("blank_valid", 32'(out_valid), 32'h0);

        // Key-coloured layer 0 is transparent: background shows, no collision.
        pixel(6'b000001, pk(12'h000, 12'h000, 12'h000, 12'h000));
        pixel(6'b000011, pk(12'h000, 12'h123, 12'h000, 12'h000));
        check("key_bg_rgb", 32'(out_rgb), 32'h00F);
        idle();
        check("key_l1_rgb", 32'(out_rgb), 32'h123);
        fend();
        check("no_coll_hit", 32'(hit), 32'h0);
        check("no_coll_count", 32'(hit_count), 32'h0);

        // Mid-frame overlap of layers 0 and 2.
        pixel(EN_OVL, pk(12'hFFF, 12'h000, 12'h0F0, 12'h000));
        pixel(6'b001000, pk(12'h000, 12'h000, 12'h000, 12'h333));
        check("ovl_rgb", 32'(out_rgb), 32'hFFF);
        pixel(6'b000100, pk(12'h000, 12'h000, 12'h0F0, 12'h000));
        fend();
        check("mid_hit", 32'(hit), 32'h1);
        check("mid_count", 32'(hit_count), 32'h1);
        idle();
        check("mid_hit_pulse", 32'(hit), 32'h0);
        pixel(6'b000010, pk(12'h000, 12'h0F0, 12'h000, 12'h000));
        fend();
        check("next_frame_hit", 32'(hit), 32'h0);
        check("next_frame_count", 32'(hit_count), 32'h1);

        // Overlap on the last pixel, judged alongside frame_end.
        pixel(6'b000001, pk(12'h0AA, 12'h000, 12'h000, 12'h000));
        pixel(6'b000011, pk(12'h0AA, 12'h0BB, 12'h000, 12'h000));
        fend();
        check("edge_hit", 32'(hit), 32'h1);
        check("edge_count", 32'(hit_count), 32'h2);
        pixel(6'b000001, pk(12'h0AA, 12'h000, 12'h000, 12'h000));
        fend();
        check("edge_next_hit", 32'(hit), 32'h0);

        // Attract mode: start_rgb shown, collisions ignored, count kept.
        start_rgb = 12'h5A5;
        step(1'b1, 1'b0, 1'b0, EN_OVL, pk(12'hFFF, 12'h000, 12'h0F0, 12'h000));
        step(1'b1, 1'b0, 1'b0, EN_OVL, pk(12'hFFF, 12'h000, 12'h0F0, 12'h000));
        check("attract_rgb", 32'(out_rgb), 32'h5A5);
        step(1'b0, 1'b1, 1'b0, '0, '0);
        check("attract_hit", 32'(hit), 32'h0);
        check("attract_count", 32'(hit_count), 32'h2);
        idle();

        // Saturation at 255 colliding frames.
        repeat (253) begin
            pixel(EN_OVL, pk(12'hFFF, 12'h000, 12'h0F0, 12'h000));
            fend();
        end
        check("sat_reach", 32'(hit_count), 32'hFF);
        pixel(EN_OVL, pk(12'hFFF, 12'h000, 12'h0F0, 12'h000));
        fend();
        check("sat_hit", 32'(hit), 32'h1);
        check("sat_hold", 32'(hit_count), 32'hFF);

        // Reset mid-frame after an overlap discards the pending collision.
        pixel(EN_OVL, pk(12'hFFF, 12'h000, 12'h0F0, 12'h000));
        pixel(6'b000010, pk(12'h000, 12'h0F0, 12'h000, 12'h000));
        check("pre_rst_valid", 32'(out_valid), 32'h1);
        mid_reset();
        idle();
        check("post_rst_stale", 32'(out_valid), 32'h0);
        pixel(6'b000010, pk(12'h000, 12'h0F0, 12'h000, 12'h000));
        fend();
        check("post_rst_rgb", 32'(out_rgb), 32'h0F0);
        check("post_rst_hit", 32'(hit), 32'h0);
        check("post_rst_count", 32'(hit_count), 32'h0);
        idle();
        idle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/layer_compositor.md
LAYER_COMPOSITOR -- requirements
Module: layer_compositor

Interface
REQ-001 SHALL have parameter N_LAYERS, default 6, number of sprite layers (range 2..16); layer 0 has highest priority.
REQ-002 SHALL have parameter RGB_W, default 12, pixel colour width.
REQ-003 SHALL have parameter KEY_RGB, default 12'h000, transparent colour key (RGB_W bits).
REQ-004 SHALL have parameters MASK_A and MASK_B, N_LAYERS bits each, defaults 6'b000001 and 6'b000110, the two layer groups tested for collision.
REQ-005 SHALL have port clk, input, 1, pixel clock; the block's only clock.
REQ-006 SHALL have port rst, input, 1; reset is asynchronous and active-low.
REQ-007 SHALL have port pix_valid, input, 1, active-area pixel strobe.
REQ-008 SHALL have port frame_end, input, 1, one-cycle pulse after the last pixel of a frame.
REQ-009 SHALL have port play_en, input, 1; 0 selects start_rgb and bypasses layers.
REQ-010 SHALL have port layer_en, input, N_LAYERS, per-layer coverage at the current pixel.
REQ-011 SHALL have port layer_rgb, input, N_LAYERS*RGB_W, packed colours; layer i occupies bits [i*RGB_W +: RGB_W].
REQ-012 SHALL have ports bg_rgb and start_rgb, input, RGB_W each.
REQ-013 SHALL have port out_rgb, output, RGB_W, registered composited pixel.
REQ-014 SHALL have port out_valid, output, 1, registered pix_valid delayed to match out_rgb.
REQ-015 SHALL have port hit, output, 1, one-cycle pulse the cycle after frame_end if a collision occurred in that frame.
REQ-016 SHALL have port hit_count, output, 8, saturating count of frames with a collision.

Function
REQ-017 Layer i SHALL be opaque when layer_en[i]=1, layer_rgb slice != KEY_RGB, and pix_valid=1.
REQ-018 Stage 1 SHALL register the opaque vector, all layer colours, bg_rgb, start_rgb, play_en and pix_valid.
REQ-019 Stage 2 SHALL register out_rgb: start_rgb if play_en=0; otherwise the lowest-index opaque layer; otherwise bg_rgb.
REQ-020 Latency SHALL be exactly 2 clk cycles from inputs to out_rgb/out_valid, with no stalls.
REQ-021 out_rgb SHALL be 0 whenever stage-2 valid is 0 (blanking).
REQ-022 A collision SHALL be recorded in the per-frame flag when, in stage 1, (opaque & MASK_A) != 0, (opaque & MASK_B) != 0, and play_en=1.
REQ-023 On frame_end, hit SHALL equal the per-frame flag OR a collision in the same cycle, and the flag SHALL clear on the next cycle.
REQ-024 hit_count SHALL increment on each hit pulse and hold at 8'hFF (no wrap).
REQ-025 A collision coinciding with frame_end SHALL be counted in the ending frame, never the next.
REQ-026 play_en=0 SHALL suppress collision recording but SHALL NOT clear hit_count.

Reset
REQ-027 While rst=0, all pipeline registers, out_rgb, out_valid, hit, the frame flag and hit_count SHALL be 0, asynchronously.
REQ-028 After rst deasserts, the first valid out_rgb SHALL appear 2 cycles after the first pix_valid, with no stale data.
REQ-029 Reset mid-frame SHALL discard the pending collision flag; no hit is produced for that frame.

Structure
REQ-030 RGB_W, KEY_RGB and the game layer-index constants (MYPLANE, ENEMY, BOSS, MYBULLET, EBULLET) SHALL live in shared package game_pkg.
REQ-031 The priority select SHALL be one sub-module, prio_select (N_LAYERS-wide one-hot-first encoder plus mux); the rest stays flat.

Verification
REQ-032 layer_en=6'b000110, layer1=12'hF00, layer2=12'h0F0, pix_valid=1 -> out_rgb=12'hF00 two cycles later; out_valid=1.
REQ-033 layer_en=6'b000001 with layer0=12'h000 (key), bg_rgb=12'h00F -> out_rgb=12'h00F; no collision.
REQ-034 layer0 and layer2 opaque for one pixel mid-frame, then frame_end -> hit=1 for one cycle, hit_count 0->1; next frame without overlap -> hit=0.
REQ-035 Overlap in the same cycle as frame_end -> hit for that frame only; the following frame reports no hit.
REQ-036 Preload 255 hit frames, then one more -> hit_count stays 8'hFF.
REQ-037 rst=0 asserted mid-frame after an overlap -> outputs 0 immediately; after release, frame_end -> no hit.
